fft_out_collector: RTL and testbench

Frame collector for the dual-lane output stream of the in-place FFT core. It captures one 64-point result frame, delivered as 32 beats of two complex samples, into a local buffer. It then replays the frame one sample per cycle over a valid/ready stream toward downstream logic (magnitude, DMA or file-dump benches). It sits directly after the FFT core's `output_start`/`outReal0..outImag1` port.

---
 rtl/fft_out_pkg.sv | 29 ++
 rtl/fft_dual_wr_buf.sv | 30 +++
 rtl/fft_out_collector.sv | 108 ++++++++++
 tb/tb_fft_out_collector.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_out_pkg.sv
// Shared types and defaults for the FFT frame output collector.
// Optional FFT_BITREV_EN reorders bit-reversed frames into natural bin order.
package fft_out_pkg;

  localparam int DW_DEF    = 16;
  localparam int N_DEF     = 64;
  localparam int LOG2N_DEF = $clog2(N_DEF);
  localparam int BR_MAXW   = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

  // Reverse the low w bits of x; w must not exceed BR_MAXW.
  function automatic logic [BR_MAXW-1:0] bitrev(
    input logic [BR_MAXW-1:0] x,
    input int unsigned        w
  );
    logic [BR_MAXW-1:0] r;
    r = '0;
    for (int i = 0; i < BR_MAXW; i++) begin
      r[i] = x[BR_MAXW-1-i];
    end
    return r >> (BR_MAXW - w);
  endfunction

endpackage

// File: rtl/fft_dual_wr_buf.sv
// Frame buffer: N words of {re,im}, paired writes at 2k/2k+1,
// one asynchronous read port, no reset.
module fft_dual_wr_buf
  import fft_out_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int N     = N_DEF,
  parameter int LOG2N = $clog2(N)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [LOG2N-2:0]  waddr,
  input  logic [2*DW-1:0]   wdata0,
  input  logic [2*DW-1:0]   wdata1,
  input  logic [LOG2N-1:0]  raddr,
  output logic [2*DW-1:0]   rdata
);

  logic [2*DW-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[{waddr, 1'b0}] <= wdata0;
      mem[{waddr, 1'b1}] <= wdata1;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fft_out_collector.sv
// Captures one dual-lane FFT frame, then replays it over valid/ready.
// Define FFT_BITREV_EN to read the buffer in bit-reversed order.
module fft_out_collector
  import fft_out_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int N     = N_DEF,
  parameter int LOG2N = $clog2(N)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_start,
  input  logic [DW-1:0]    in_re0,
  input  logic [DW-1:0]    in_im0,
  input  logic [DW-1:0]    in_re1,
  input  logic [DW-1:0]    in_im1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_re,
  output logic [DW-1:0]    out_im,
  output logic [LOG2N-1:0] out_idx,
  output logic             out_last,
  output logic             busy,
  output logic             overrun
);

  localparam int HW = LOG2N - 1;

  state_e           st;
  logic [HW-1:0]    wcnt;
  logic [LOG2N-1:0] rcnt;
  logic             ovr;

  logic             we;
  logic [HW-1:0]    waddr;
  logic [LOG2N-1:0] raddr;
  logic [2*DW-1:0]  rdata;
  logic             last_beat;
  logic             xfer;

  assign we        = (st == ST_IDLE && in_start) || st == ST_CAPTURE;
  assign waddr     = (st == ST_CAPTURE) ? wcnt : '0;
  assign last_beat = wcnt == HW'(N/2 - 1);
  assign xfer      = out_valid && out_ready;

`ifdef FFT_BITREV_EN
  assign raddr = LOG2N'(bitrev(BR_MAXW'(rcnt), LOG2N));
`else
  assign raddr = rcnt;
`endif

  fft_dual_wr_buf #(
    .DW    (DW),
    .N     (N),
    .LOG2N (LOG2N)
  ) u_buf (
    .clk    (clk),
    .we     (we),
    .waddr  (waddr),
    .wdata0 ({in_re0, in_im0}),
    .wdata1 ({in_re1, in_im1}),
    .raddr  (raddr),
    .rdata  (rdata)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      st   <= ST_IDLE;
      wcnt <= '0;
      rcnt <= '0;
      ovr  <= 1'b0;
    end else begin
      // A start while busy drops that frame entirely.
      if (in_start && st != ST_IDLE) ovr <= 1'b1;
      unique case (st)
        ST_IDLE: begin
          if (in_start) begin
            st   <= ST_CAPTURE;
            wcnt <= HW'(1);
          end
        end
        ST_CAPTURE: begin
          wcnt <= wcnt + 1'b1;
          if (last_beat) begin
            st   <= ST_DRAIN;
            rcnt <= '0;
          end
        end
        ST_DRAIN: begin
          if (xfer) begin
            rcnt <= rcnt + 1'b1;
            if (&rcnt) st <= ST_IDLE;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = st == ST_DRAIN;
  assign out_re    = out_valid ? rdata[2*DW-1:DW] : '0;
  assign out_im    = out_valid ? rdata[DW-1:0] : '0;
  assign out_idx   = rcnt;
  assign out_last  = out_valid && (&rcnt);
  assign busy      = st != ST_IDLE;
  assign overrun   = ovr;

endmodule

// File: tb/tb_fft_out_collector.sv
// Scoreboard bench for fft_out_collector: directed frames,
// expected samples queued at issue, checked by a monitor.
module tb_fft_out_collector;

  localparam int DW = 16;
  localparam int N  = 64;
  localparam int LG = 6;

  logic          clk = 1'b0;
  logic          nrst;
  logic          in_start;
  logic [DW-1:0] in_re0, in_im0, in_re1, in_im1;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_re, out_im;
  logic [LG-1:0] out_idx;
  logic          out_last, busy, overrun;

  always #5 clk = ~clk;

  fft_out_collector #(.DW(DW), .N(N), .LOG2N(LG)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .in_start  (in_start),
    .in_re0    (in_re0),
    .in_im0    (in_im0),
    .in_re1    (in_re1),
    .in_im1    (in_im1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .overrun   (overrun)
  );

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    int            idx;
  } exp_t;

  exp_t q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int xfers, vcyc, start_cyc, rise_cyc;
  logic prev_v, hold_v, bp_en, phase;
  logic [DW-1:0] hold_re, hold_im;
  logic [LG-1:0] hold_idx;
  logic [DW-1:0] fr_re[N];
  logic [DW-1:0] fr_im[N];
  logic [DW-1:0] got_re[N];
  logic [DW-1:0] got_im[N];

  always @(posedge clk) cyc++;

  function automatic int br(input int x);
    int r;
    r = 0;
    for (int i = 0; i < LG; i++)
      if (x[i]) r |= 1 << (LG - 1 - i);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every transfer.
  always @(negedge clk) begin
    exp_t e;
    if (nrst) begin
      if (out_valid && !prev_v) rise_cyc = cyc;
      prev_v = out_valid;
      if (out_valid) vcyc++;
      if (hold_v && out_valid) begin
        chk("hold_re", 32'(out_re), 32'(hold_re));
        chk("hold_im", 32'(out_im), 32'(hold_im));
        chk("hold_idx", 32'(out_idx), 32'(hold_idx));
      end
      hold_v = 1'b0;
      if (out_valid && !out_ready) begin
        hold_v   = 1'b1;
        hold_re  = out_re;
        hold_im  = out_im;
        hold_idx = out_idx;
      end
      if (out_valid && out_ready) begin
        xfers++;
        if (q.size() == 0) begin
          chk("unexpected_xfer", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("out_re", 32'(out_re), 32'(e.re));
          chk("out_im", 32'(out_im), 32'(e.im));
          chk("out_idx", 32'(out_idx), 32'(e.idx));
          chk("out_last", 32'(out_last), 32'(e.idx == N - 1));
          got_re[out_idx] = out_re;
          got_im[out_idx] = out_im;
        end
      end
    end else begin
      prev_v = 1'b0;
      hold_v = 1'b0;
    end
  end

  // Ready driver: alternates 1,0,1,... while draining under backpressure.
  always @(posedge clk) begin
    #1;
    if (bp_en) begin
      if (out_valid) begin
        out_ready = phase;
        phase     = !phase;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  task automatic send_frame(input int abort_at, input bit keep);
    exp_t e;
    int a;
    if (keep) begin
      for (int r = 0; r < N; r++) begin
`ifdef FFT_BITREV_EN
        a = br(r);
`else
        a = r;
`endif
        e.re  = fr_re[a];
        e.im  = fr_im[a];
        e.idx = r;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    start_cyc = cyc;
    in_start  = 1'b1;
    for (int b = 0; b < N/2; b++) begin
      if (b > 0) begin
        @(posedge clk);
        #1;
        in_start = 1'b0;
      end
      if (b == abort_at) begin
        nrst     = 1'b0;
        in_start = 1'b0;
        return;
      end
      in_re0 = fr_re[2*b];
      in_im0 = fr_im[2*b];
      in_re1 = fr_re[2*b+1];
      in_im1 = fr_im[2*b+1];
    end
    @(posedge clk);
    #1;
    in_start = 1'b0;
    in_re0 = '0; in_im0 = '0; in_re1 = '0; in_im1 = '0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_re"}, 32'(out_re), 32'd0);
    chk({tag, "_im"}, 32'(out_im), 32'd0);
    chk({tag, "_idx"}, 32'(out_idx), 32'd0);
    chk({tag, "_last"}, 32'(out_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    nrst = 1'b0; in_start = 1'b0; out_ready = 1'b1;
    in_re0 = '0; in_im0 = '0; in_re1 = '0; in_im1 = '0;
    bp_en = 1'b0; phase = 1'b1; prev_v = 1'b0; hold_v = 1'b0;
    xfers = 0; vcyc = 0; rise_cyc = 0; start_cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("rst");
    nrst = 1'b1;

    // Ramp frame, ready held high.
    for (int i = 0; i < N; i++) begin
      fr_re[i] = 16'(i);
      fr_im[i] = 16'(-i);
    end
    xfers = 0; vcyc = 0;
    send_frame(-1, 1'b1);
    chk("ramp_busy", 32'(busy), 32'd1);
    wait_idle(200);
    chk("ramp_latency", 32'(rise_cyc - start_cyc), 32'd32);
    chk("ramp_xfers", 32'(xfers), 32'd64);
    chk("ramp_vcyc", 32'(vcyc), 32'd64);
    chk("ramp_valid_after", 32'(out_valid), 32'd0);
    chk("ramp_overrun", 32'(overrun), 32'd0);
`ifdef FFT_BITREV_EN
    chk("ramp_bin1", 32'(got_re[1]), 32'd32);
    chk("ramp_bin3", 32'(got_re[3]), 32'd48);
`else
    chk("ramp_bin1", 32'(got_re[1]), 32'd1);
    chk("ramp_bin3", 32'(got_re[3]), 32'd3);
`endif
    chk("ramp_bin63", 32'(got_re[63]), 32'd63);
    chk("ramp_im63", 32'(got_im[63]), 32'(16'hFFC1));

    // Backpressure with ready toggling 1,0,1,...
    for (int i = 0; i < N; i++) begin
      fr_re[i] = 16'(3 * i + 100);
      fr_im[i] = 16'(1000 - 7 * i);
    end
    xfers = 0; vcyc = 0; phase = 1'b1; bp_en = 1'b1;
    send_frame(-1, 1'b1);
    wait_idle(400);
    bp_en = 1'b0;
    out_ready = 1'b1;
    chk("bp_xfers", 32'(xfers), 32'd64);
    chk("bp_vcyc", 32'(vcyc), 32'd127);

    // Start pulse during drain is dropped.
    for (int i = 0; i < N; i++) begin
      fr_re[i] = 16'(i + 200);
      fr_im[i] = 16'(-2 * i);
    end
    xfers = 0; vcyc = 0;
    send_frame(-1, 1'b1);
    n = 0;
    while (!(out_valid && out_idx == 6'd10) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ovr_reach10", 32'(out_idx), 32'd10);
    in_start = 1'b1;
    in_re0 = 16'h1234; in_im0 = 16'h5678;
    in_re1 = 16'h9ABC; in_im1 = 16'hDEF0;
    @(posedge clk);
    #1;
    in_start = 1'b0;
    chk("ovr_flag", 32'(overrun), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    in_re0 = '0; in_im0 = '0; in_re1 = '0; in_im1 = '0;
    wait_idle(200);
    chk("ovr_xfers", 32'(xfers), 32'd64);
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // Reset in the middle of capture, then a full frame.
    for (int i = 0; i < N; i++) begin
      fr_re[i] = 16'h0F00 + 16'(i);
      fr_im[i] = 16'h0AA0;
    end
    send_frame(15, 1'b0);
    #2;
    chk_all_zero("midrst");
    @(posedge clk);
    #1;
    nrst = 1'b1;
    for (int i = 0; i < N; i++) begin
      fr_re[i] = 16'hF000 + 16'(i);
      fr_im[i] = 16'(i * 257);
    end
    xfers = 0; vcyc = 0;
    send_frame(-1, 1'b1);
    wait_idle(200);
    chk("post_rst_xfers", 32'(xfers), 32'd64);
    chk("post_rst_overrun", 32'(overrun), 32'd0);

    // Full-scale extremes pass through untouched.
    for (int i = 0; i < N; i++) begin
      fr_re[i] = 16'(i);
      fr_im[i] = 16'd0;
    end
    fr_re[0] = 16'h8000;
    fr_im[1] = 16'h7FFF;
    xfers = 0; vcyc = 0;
    send_frame(-1, 1'b1);
    wait_idle(200);
    chk("ext_re0", 32'(got_re[0]), 32'h8000);
`ifdef FFT_BITREV_EN
    chk("ext_im1", 32'(got_im[32]), 32'h7FFF);
`else
    chk("ext_im1", 32'(got_im[1]), 32'h7FFF);
`endif
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
